bb_core: RTL and testbench
==========================

// Module: bb_core
// PURPOSE
// - Parametrised ByteBlast accumulator CPU core: fetch/decode/execute sequencer, PC, IR, ACC, ALU in one block.
// - Talks to one synchronous-read RAM: read data is valid the cycle after the address is presented.
// - Replaces the loose pc/ctrl/fde/mux4 assembly. Adds SUB, HLT, flags and optional jumps.
// PARAMETERS
// - DATA_BITS  8  data and instruction word width; instruction = {op[2:0], addr[DATA_BITS-4:0]}
// - RESET_PC   0  PC value loaded on reset
// - localparam ADDR_BITS = DATA_BITS-3 (memory depth 2**ADDR_BITS)
// PORTS
// - clk        in   1          rising-edge clock
// - reset      in   1          synchronous, active-high
// - enable     in   1          1 = advance; 0 = freeze all state, mem_we forced 0
// - mem_addr   out  ADDR_BITS  RAM address (combinational from state)
// - mem_rdata  in   DATA_BITS  RAM read data (registered inside the RAM, 1-cycle latency)
// - mem_wdata  out  DATA_BITS  RAM write data (= acc)
// - mem_we     out  1          RAM write strobe; write occurs on the clk edge ending EXECUTE
// - acc        out  DATA_BITS  accumulator
// - pc         out  ADDR_BITS  program counter
// - fde_state  out  2          00 FETCH, 01 DECODE, 10 EXECUTE, 11 HALT
// - zero       out  1          set when the last LD/ADD/SUB result == 0
// - carry      out  1          carry out of ADD; borrow out of SUB
// - halted     out  1          1 while fde_state == HALT
// BEHAVIOUR
// - Reset (takes priority over enable): fde_state=FETCH, pc=RESET_PC, ir=0, acc=0, zero=0, carry=0, halted=0, mem_we=0.
// - Reset mid-instruction aborts the instruction. No write is issued in the reset cycle.
// - Opcodes: 000 NOP, 001 LD, 010 ADD, 011 SUB, 100 STR, 101 JMP, 110 JZ, 111 HLT.
// - FETCH: mem_addr=pc. At the edge: pc<=pc+1 (mod 2**ADDR_BITS, so 2**ADDR_BITS-1 wraps to 0), then go to DECODE.
// - DECODE: mem_rdata holds the instruction. mem_addr=mem_rdata[ADDR_BITS-1:0] (operand prefetch).
// - At the end of DECODE: ir<=mem_rdata. HLT goes to HALT; all other opcodes go to EXECUTE.
// - EXECUTE: mem_addr=ir.addr, mem_rdata=M[ir.addr]. At the edge, go to FETCH and apply the opcode:
//   - LD: acc<=M. zero updated; carry unchanged.
//   - ADD: {carry,acc}<=acc+M. zero updated.
//   - SUB: acc<=acc-M. carry=1 iff acc<M (unsigned). zero updated.
//   - STR: mem_we=1 and mem_wdata=acc during this cycle. Flags unchanged.
//   - NOP: no state change except the state machine.
//   - JMP/JZ: see CONFIGURATION.
// - Every instruction takes exactly 3 enabled cycles (FETCH, DECODE, EXECUTE); HLT takes 2.
// - HALT: mem_addr=pc, mem_we=0. Stays in HALT until reset; enable has no effect.
// - enable=0: every register holds its value. mem_addr still follows the current state. mem_we=0.
//   - Dropping enable during DECODE stalls that state. The RAM must hold its output, because the core re-samples mem_rdata on resume.
// - All arithmetic is modulo 2**DATA_BITS. Operands are unsigned.
// CONFIGURATION
// - Macro BB_JUMP_EN.
// - Defined: in EXECUTE, JMP sets pc<=ir.addr. JZ sets pc<=ir.addr if zero==1, otherwise pc is unchanged. Flags unchanged.
// - Undefined: JMP and JZ execute as NOP. No jump logic is synthesised.
// STRUCTURE
// - Shared package bb_pkg: opcode constants (OP_NOP..OP_HLT), state encodings (ST_FETCH..ST_HALT), OP_BITS=3.
// - Sub-module bb_alu (combinational, parameter DATA_BITS): inputs a, b, op; outputs result, carry, zero.
// - Sequencer, PC, IR and ACC registers live in bb_core itself.
// TESTING
// - Program M0=001_00011 (LD 3), M1=010_00100 (ADD 4), M2=100_00101 (STR 5), M3=2, M4=5, M5=0.
//   After 9 cycles: M5=7, acc=7, pc=3, carry=0.
// - LD of 0xFF, then ADD of 0x01 -> acc=0x00, carry=1, zero=1.
// - SUB: acc=3, M=5 -> acc=0xFE, carry=1, zero=0.
// - HLT at address 6 -> halted=1 two cycles after FETCH of address 6. pc=7 holds for 20 cycles.
//   Asserting reset for 1 cycle -> FETCH, pc=0.
// - enable=0 for 4 cycles mid-DECODE of the ADD -> pc, acc and state frozen, mem_we=0.
//   Final M5=7 is still reached with 4 extra cycles.
// - With BB_JUMP_EN: JMP 31 -> pc=31. Next FETCH wraps pc to 0.
//   JZ taken only when zero=1; as NOP when the macro is undefined.
// - Assert reset during the EXECUTE of STR -> no write to M5. Registers reach reset values on the next edge.

Source files
------------

// File: rtl/bb_pkg.sv
// Shared ByteBlast definitions: opcode and sequencer-state encodings.
package bb_pkg;

    localparam int unsigned OP_BITS  = 3;
    localparam int unsigned FDE_BITS = 2;

    typedef enum logic [OP_BITS-1:0] {
        OP_NOP = 3'b000,
        OP_LD  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_STR = 3'b100,
        OP_JMP = 3'b101,
        OP_JZ  = 3'b110,
        OP_HLT = 3'b111
    } op_e;

    typedef enum logic [FDE_BITS-1:0] {
        ST_FETCH   = 2'b00,
        ST_DECODE  = 2'b01,
        ST_EXECUTE = 2'b10,
        ST_HALT    = 2'b11
    } state_e;

    // Opcode field of an instruction word whose top OP_BITS bits hold the op.
    function automatic op_e op_of(input logic [OP_BITS-1:0] top_bits);
        return op_e'(top_bits);
    endfunction

endpackage

// File: rtl/bb_alu.sv
// ByteBlast ALU: LD pass-through, ADD with carry-out, SUB with borrow-out.
module bb_alu
    import bb_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic [DATA_BITS-1:0] i_a,
    input  logic [DATA_BITS-1:0] i_b,
    input  op_e                  i_op,
    output logic [DATA_BITS-1:0] o_result,
    output logic                 o_carry,
    output logic                 o_zero
);

    logic [DATA_BITS:0] w_sum;
    logic [DATA_BITS:0] w_diff;

    // Extra MSB carries the carry (ADD) or the borrow (SUB, set when a < b).
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_result = i_a;
        o_carry  = 1'b0;
        case (i_op)
            OP_LD:   o_result = i_b;
            OP_ADD:  {o_carry, o_result} = w_sum;
            OP_SUB:  {o_carry, o_result} = w_diff;
            default: ;
        endcase
        o_zero = (o_result == '0);
    end

endmodule

// File: rtl/bb_core.sv
// ByteBlast accumulator core: FETCH/DECODE/EXECUTE sequencer with PC, IR, ACC and flags.
// Optional macro BB_JUMP_EN enables JMP/JZ; when undefined both execute as NOP.
module bb_core
    import bb_pkg::*;
#(
    parameter  int unsigned DATA_BITS = 8,
    parameter  int unsigned RESET_PC  = 0,
    localparam int unsigned ADDR_BITS = DATA_BITS - 3
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    output logic [ADDR_BITS-1:0] o_mem_addr,
    input  logic [DATA_BITS-1:0] i_mem_rdata,
    output logic [DATA_BITS-1:0] o_mem_wdata,
    output logic                 o_mem_we,
    output logic [DATA_BITS-1:0] o_acc,
    output logic [ADDR_BITS-1:0] o_pc,
    output logic [FDE_BITS-1:0]  o_fde_state,
    output logic                 o_zero,
    output logic                 o_carry,
    output logic                 o_halted
);

    state_e               r_state;
    logic [ADDR_BITS-1:0] r_pc;
    logic [DATA_BITS-1:0] r_ir;
    logic [DATA_BITS-1:0] r_acc;
    logic                 r_zero;
    logic                 r_carry;
    logic                 r_halted;

    op_e                  w_ir_op;
    op_e                  w_fetched_op;
    logic [ADDR_BITS-1:0] w_ir_addr;
    logic [ADDR_BITS-1:0] w_mem_addr;
    logic [DATA_BITS-1:0] w_alu_result;
    logic                 w_alu_carry;
    logic                 w_alu_zero;

    assign w_ir_op      = op_of(r_ir[DATA_BITS-1 -: OP_BITS]);
    assign w_ir_addr    = r_ir[ADDR_BITS-1:0];
    assign w_fetched_op = op_of(i_mem_rdata[DATA_BITS-1 -: OP_BITS]);

    bb_alu #(
        .DATA_BITS (DATA_BITS)
    ) u_alu (
        .i_a      (r_acc),
        .i_b      (i_mem_rdata),
        .i_op     (w_ir_op),
        .o_result (w_alu_result),
        .o_carry  (w_alu_carry),
        .o_zero   (w_alu_zero)
    );

    // DECODE presents the operand address straight from the fetched word so it arrives in EXECUTE.
    always_comb begin
        w_mem_addr = r_pc;
        case (r_state)
            ST_DECODE:  w_mem_addr = i_mem_rdata[ADDR_BITS-1:0];
            ST_EXECUTE: w_mem_addr = w_ir_addr;
            default:    ;
        endcase
    end

    assign o_mem_addr  = w_mem_addr;
    assign o_mem_wdata = r_acc;
    assign o_mem_we    = (r_state == ST_EXECUTE) && (w_ir_op == OP_STR) && i_enable && !i_reset;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= ST_FETCH;
            r_pc     <= ADDR_BITS'(RESET_PC);
            r_ir     <= '0;
            r_acc    <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_halted <= 1'b0;
        end else if (i_enable) begin
            case (r_state)
                ST_FETCH: begin
                    r_pc    <= r_pc + ADDR_BITS'(1);
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    r_ir <= i_mem_rdata;
                    if (w_fetched_op == OP_HLT) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    r_state <= ST_FETCH;
                    case (w_ir_op)
                        OP_LD: begin
                            r_acc  <= w_alu_result;
                            r_zero <= w_alu_zero;
                        end
                        OP_ADD, OP_SUB: begin
                            r_acc   <= w_alu_result;
                            r_zero  <= w_alu_zero;
                            r_carry <= w_alu_carry;
                        end
`ifdef BB_JUMP_EN
                        OP_JMP: r_pc <= w_ir_addr;
                        OP_JZ: begin
                            if (r_zero) begin
                                r_pc <= w_ir_addr;
                            end
                        end
`endif
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign o_acc       = r_acc;
    assign o_pc        = r_pc;
    assign o_fde_state = r_state;
    assign o_zero      = r_zero;
    assign o_carry     = r_carry;
    assign o_halted    = r_halted;

endmodule

// File: tb/tb_bb_core.sv
// Self-checking bench for bb_core: directed vectors, multi-cycle corner cases and
// random programs checked against an instruction-level reference model.
`timescale 1ns/1ps
module tb_bb_core;
    import bb_pkg::*;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = DW - 3;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] acc;
    logic [AW-1:0] pc;
    logic [1:0]    fde_state;
    logic          zero;
    logic          carry;
    logic          halted;

    always #5 clk = ~clk;

    bb_core #(.DATA_BITS(DW), .RESET_PC(0)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_enable    (enable),
        .o_mem_addr  (mem_addr),
        .i_mem_rdata (mem_rdata),
        .o_mem_wdata (mem_wdata),
        .o_mem_we    (mem_we),
        .o_acc       (acc),
        .o_pc        (pc),
        .o_fde_state (fde_state),
        .o_zero      (zero),
        .o_carry     (carry),
        .o_halted    (halted)
    );

    // Synchronous-read RAM; output held while the core is stalled.
    logic [DW-1:0] ram      [DEPTH];
    logic [DW-1:0] init_mem [DEPTH];
    logic          load;

    always @(posedge clk) begin
        if (load) ram <= init_mem;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        if (enable) mem_rdata <= ram[mem_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_init();
        for (int i = 0; i < DEPTH; i++) init_mem[i] = '0;
    endtask

    task automatic do_reset();
        enable = 1'b1;
        reset  = 1'b1;
        load   = 1'b1;
        tick();
        load  = 1'b0;
        reset = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Instruction-level reference model.
    logic [DW-1:0] mm [DEPTH];
    logic [AW-1:0] m_pc;
    logic [DW-1:0] m_acc;
    logic          m_zero, m_carry, m_halt;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mm[i] = init_mem[i];
        m_pc = '0; m_acc = '0; m_zero = 1'b0; m_carry = 1'b0; m_halt = 1'b0;
    endtask

    task automatic model_step();
        logic [DW-1:0] ins, opnd;
        logic [2:0]    op;
        logic [AW-1:0] a;
        logic [DW:0]   s;
        ins  = mm[m_pc];
        op   = ins[DW-1 -: 3];
        a    = ins[AW-1:0];
        opnd = mm[a];
        m_pc = m_pc + AW'(1);
        case (op)
            3'd1: begin m_acc = opnd; m_zero = (m_acc == 0); end
            3'd2: begin
                s = {1'b0, m_acc} + {1'b0, opnd};
                m_carry = s[DW]; m_acc = s[DW-1:0]; m_zero = (m_acc == 0);
            end
            3'd3: begin
                m_carry = (m_acc < opnd); m_acc = m_acc - opnd; m_zero = (m_acc == 0);
            end
            3'd4: mm[a] = m_acc;
`ifdef BB_JUMP_EN
            3'd5: m_pc = a;
            3'd6: if (m_zero) m_pc = a;
`endif
            3'd7: m_halt = 1'b1;
            default: ;
        endcase
    endtask

    task automatic check_arch(input string tag);
        check({tag, ".pc"},     32'(pc),     32'(m_pc));
        check({tag, ".acc"},    32'(acc),    32'(m_acc));
        check({tag, ".zero"},   32'(zero),   32'(m_zero));
        check({tag, ".carry"},  32'(carry),  32'(m_carry));
        check({tag, ".halted"}, 32'(halted), 32'(m_halt));
        check({tag, ".state"},  32'(fde_state), m_halt ? 32'd3 : 32'd0);
    endtask

    typedef struct {
        logic [2:0]    op;
        logic [DW-1:0] a0;
        logic [DW-1:0] b;
        logic [DW-1:0] e_acc;
        logic          e_c;
        logic          e_z;
    } vec_t;

    vec_t vt [8];

    task automatic load_demo();
        clear_init();
        init_mem[0] = 8'h23;
        init_mem[1] = 8'h44;
        init_mem[2] = 8'h85;
        init_mem[3] = 8'd2;
        init_mem[4] = 8'd5;
        init_mem[5] = 8'd0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] b;
        int            len, n, guard, bad_words;

        reset = 1'b1; enable = 1'b1; load = 1'b0;
        clear_init();

        vt[0] = '{3'b010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
        vt[1] = '{3'b011, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        vt[2] = '{3'b010, 8'h02, 8'h05, 8'h07, 1'b0, 1'b0};
        vt[3] = '{3'b011, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1};
        vt[4] = '{3'b001, 8'h07, 8'h00, 8'h00, 1'b0, 1'b1};
        vt[5] = '{3'b000, 8'h80, 8'h12, 8'h80, 1'b0, 1'b0};
        vt[6] = '{3'b010, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vt[7] = '{3'b011, 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0};

        // Demo program: reset values, STR strobe, final result after 9 cycles.
        load_demo();
        reset = 1'b1; load = 1'b1; tick(); load = 1'b0;
        check("rst.state", 32'(fde_state), 32'd0);
        check("rst.pc", 32'(pc), 32'd0);
        check("rst.acc", 32'(acc), 32'd0);
        check("rst.flags", {30'd0, zero, carry}, 32'd0);
        check("rst.halted", 32'(halted), 32'd0);
        check("rst.we", 32'(mem_we), 32'd0);
        reset = 1'b0;
        run(8);
        check("demo.exec_state", 32'(fde_state), 32'd2);
        check("demo.we", 32'(mem_we), 32'd1);
        check("demo.wdata", 32'(mem_wdata), 32'd7);
        check("demo.addr", 32'(mem_addr), 32'd5);
        tick();
        check("demo.m5", 32'(ram[5]), 32'd7);
        check("demo.acc", 32'(acc), 32'd7);
        check("demo.pc", 32'(pc), 32'd3);
        check("demo.carry", 32'(carry), 32'd0);

        // Stall for 4 cycles in DECODE of ADD.
        load_demo();
        do_reset();
        run(4);
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 check("stall.we", 32'(mem_we), 32'd0);
            tick();
        end
        check("stall.pc", 32'(pc), 32'd2);
        check("stall.acc", 32'(acc), 32'd2);
        check("stall.state", 32'(fde_state), 32'd1);
        enable = 1'b1;
        run(5);
        check("stall.m5", 32'(ram[5]), 32'd7);
        check("stall.acc_end", 32'(acc), 32'd7);
        check("stall.pc_end", 32'(pc), 32'd3);

        // Reset during EXECUTE of STR suppresses the write.
        load_demo();
        do_reset();
        run(8);
        reset = 1'b1;
        #1 check("rststr.we", 32'(mem_we), 32'd0);
        tick();
        reset = 1'b0;
        check("rststr.m5", 32'(ram[5]), 32'd0);
        check("rststr.state", 32'(fde_state), 32'd0);
        check("rststr.pc", 32'(pc), 32'd0);
        check("rststr.acc", 32'(acc), 32'd0);

        // HLT at address 6 after six NOPs.
        clear_init();
        init_mem[6] = 8'hE0;
        do_reset();
        run(18);
        check("hlt.fetch_pc", 32'(pc), 32'd6);
        check("hlt.fetch_state", 32'(fde_state), 32'd0);
        tick();
        check("hlt.decode_halted", 32'(halted), 32'd0);
        tick();
        check("hlt.halted", 32'(halted), 32'd1);
        check("hlt.state", 32'(fde_state), 32'd3);
        check("hlt.pc", 32'(pc), 32'd7);
        for (int i = 0; i < 20; i++) begin
            enable = 1'($urandom_range(0, 1));
            tick();
        end
        enable = 1'b1;
        check("hlt.hold_pc", 32'(pc), 32'd7);
        check("hlt.hold_halted", 32'(halted), 32'd1);
        check("hlt.hold_addr", 32'(mem_addr), 32'd7);
        check("hlt.hold_we", 32'(mem_we), 32'd0);
        reset = 1'b1; tick(); reset = 1'b0;
        check("hlt.rst_state", 32'(fde_state), 32'd0);
        check("hlt.rst_pc", 32'(pc), 32'd0);
        check("hlt.rst_halted", 32'(halted), 32'd0);

        // Table-driven ALU vectors: LD 30 then <op> 31.
        for (int v = 0; v < 8; v++) begin
            clear_init();
            init_mem[0]  = {3'b001, 5'd30};
            init_mem[1]  = {vt[v].op, 5'd31};
            init_mem[30] = vt[v].a0;
            init_mem[31] = vt[v].b;
            do_reset();
            run(6);
            check($sformatf("vec%0d.acc", v), 32'(acc), 32'(vt[v].e_acc));
            check($sformatf("vec%0d.carry", v), 32'(carry), 32'(vt[v].e_c));
            check($sformatf("vec%0d.zero", v), 32'(zero), 32'(vt[v].e_z));
            check($sformatf("vec%0d.pc", v), 32'(pc), 32'd2);
        end

        // Jumps: JMP 31 then wrap; JZ taken/not taken.
        clear_init();
        init_mem[0] = 8'hBF;
        do_reset();
        run(3);
`ifdef BB_JUMP_EN
        check("jmp.pc", 32'(pc), 32'd31);
        tick();
        check("jmp.wrap", 32'(pc), 32'd0);
`else
        check("jmp.pc", 32'(pc), 32'd1);
        tick();
        check("jmp.next", 32'(pc), 32'd2);
`endif
        for (int t = 0; t < 2; t++) begin
            clear_init();
            init_mem[0]  = 8'h2A;
            init_mem[1]  = 8'hD4;
            init_mem[10] = (t == 0) ? 8'd0 : 8'd5;
            do_reset();
            run(6);
            check($sformatf("jz%0d.zero", t), 32'(zero), (t == 0) ? 32'd1 : 32'd0);
`ifdef BB_JUMP_EN
            check($sformatf("jz%0d.pc", t), 32'(pc), (t == 0) ? 32'd20 : 32'd2);
`else
            check($sformatf("jz%0d.pc", t), 32'(pc), 32'd2);
`endif
        end

        // Random programs with random stalls against the reference model.
        for (int p = 0; p < 15; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                b = DW'($urandom);
                if (b[DW-1 -: 3] == 3'b111 && $urandom_range(0, 3) != 0) b[DW-1 -: 3] = 3'b010;
                init_mem[i] = b;
            end
            do_reset();
            model_reset();
            for (int k = 0; k < 30 && !m_halt; k++) begin
                len = (mm[m_pc][DW-1 -: 3] == 3'b111) ? 2 : 3;
                n = 0;
                guard = 0;
                while (n < len) begin
                    enable = (guard >= 8) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
                    if (enable) n++;
                    guard++;
                    tick();
                end
                enable = 1'b1;
                model_step();
                check_arch($sformatf("rnd%0d.%0d", p, k));
            end
            bad_words = 0;
            for (int i = 0; i < DEPTH; i++) if (ram[i] !== mm[i]) bad_words++;
            check($sformatf("rnd%0d.mem", p), 32'(bad_words), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
